// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter, LSB first, one start and one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_transmitter #(
    parameter int BIT_TICKS = 16
) (
    input  logic       d_Clk,
    input  logic       reset,
    input  logic       tx_Start,
    input  logic [7:0] tx_Data,
    output logic       tx,
    output logic       tx_Busy,
    output logic       tx_Done
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic [2:0]    idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    assign tick_d  = tick_q + TW'(1);
    assign bit_end = (tick_q == TICK_LAST);

    assign tx      = tx_q;
    assign tx_Busy = busy_q;
    assign tx_Done = done_q;

    // tx is updated on the same edge as the state, so the line never
    // depends on combinational decode of the FSM.
    always_ff @(posedge d_Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_Start) begin
                        shreg_q <= tx_Data;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^tx_Data;
`endif
                        tick_q  <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= SEND;
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                SEND: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        shreg_q <= shreg_q >> 1;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shreg_q[1];
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        tick_q <= tick_d;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                default: begin
                    tick_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level line model, literal frames,
// back-to-back, mid-frame reset and a behavioural loopback receiver.
module tb_uart_transmitter;

    localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * BT;

    logic       d_Clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_Start = 1'b0;
    logic [7:0] tx_Data = 8'h00;
    logic       tx;
    logic       tx_Busy;
    logic       tx_Done;

    int errors = 0;
    int checks = 0;

    always #5 d_Clk = ~d_Clk;

    uart_transmitter #(.BIT_TICKS(BT)) dut (
        .d_Clk   (d_Clk),
        .reset   (reset),
        .tx_Start(tx_Start),
        .tx_Data (tx_Data),
        .tx      (tx),
        .tx_Busy (tx_Busy),
        .tx_Done (tx_Done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Line levels of a whole frame, one entry per bit period.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Frame-level model: which frame is on the line and since which edge.
    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_base = 0;
    logic [10:0] m_bits = '1;
    int          m_done_at = -10;

    always @(posedge d_Clk) cyc <= cyc + 1;

    always @(posedge d_Clk or negedge reset) begin
        if (!reset) begin
            m_act     <= 1'b0;
            m_done_at <= -10;
        end else if (!m_act && tx_Start) begin
            m_act  <= 1'b1;
            m_base <= cyc;
            m_bits <= frame_of(tx_Data);
        end else if (m_act && (cyc - m_base == FL)) begin
            m_act     <= 1'b0;
            m_done_at <= cyc;
        end
    end

    bit   chk_en = 1'b0;
    int   c_off;
    logic c_tx;
    logic c_busy;
    logic c_done;

    always @(negedge d_Clk) begin
        if (chk_en) begin
            if (m_act) begin
                c_off  = cyc - 1 - m_base;
                c_tx   = m_bits[c_off / BT];
                c_busy = 1'b1;
            end else begin
                c_tx   = 1'b1;
                c_busy = 1'b0;
            end
            c_done = (cyc - 1 == m_done_at);
            chk("model_tx", int'(tx), int'(c_tx));
            chk("model_busy", int'(tx_Busy), int'(c_busy));
            chk("model_done", int'(tx_Done), int'(c_done));
        end
    end

    // Loopback receiver: mid-bit sampling at the oversample rate.
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_byte = '0;
    logic       rx_par = 1'b0;
    bit         rx_ok = 1'b0;
    int         rx_cnt = 0;

    always @(negedge d_Clk or negedge reset) begin
        if (!reset) begin
            rx_busy <= 1'b0;
            rx_t    <= 0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_t    <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t % BT == BT / 2) begin
                if (rx_t / BT >= 1 && rx_t / BT <= 8) begin
                    rx_sh[rx_t/BT-1] <= tx;
                end else if (rx_t / BT == FB - 1) begin
                    rx_byte <= rx_sh;
                    rx_ok   <= tx && (FB == 10 || rx_par == ^rx_sh);
                    rx_cnt  <= rx_cnt + 1;
                    rx_busy <= 1'b0;
                end else if (rx_t / BT == 9) begin
                    rx_par <= tx;
                end
            end
        end
    end

    task automatic lit_frame(input string nm, input logic [7:0] d,
                             input logic [10:0] seq, input int len);
        int done_n;
        done_n = -1;
        @(negedge d_Clk);
        tx_Data  = d;
        tx_Start = 1'b1;
        @(posedge d_Clk);
        for (int n = 0; n < FL + 40; n++) begin
            @(negedge d_Clk);
            if (n == 0) begin
                tx_Start = 1'b0;
                chk({nm, "_fall"}, int'(tx), 0);
                chk({nm, "_busy"}, int'(tx_Busy), 1);
            end
            if (n == 20) tx_Data = ~d;
            if (n % BT == BT / 2 && n / BT < FB)
                chk($sformatf("%s_bit%0d", nm, n / BT), int'(tx), int'(seq[n/BT]));
            if (tx_Done) begin
                done_n = n;
                break;
            end
        end
        chk({nm, "_len"}, done_n, len);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (tx_Busy && k < 2 * FL) begin
            @(negedge d_Clk);
            k++;
        end
        chk({nm, "_idle"}, int'(tx_Busy), 0);
    endtask

    task automatic loopback(input logic [7:0] d);
        int c0;
        int k;
        c0 = rx_cnt;
        @(negedge d_Clk);
        tx_Data  = d;
        tx_Start = 1'b1;
        @(negedge d_Clk);
        tx_Start = 1'b0;
        k = 0;
        while (rx_cnt == c0 && k < FL + 40) begin
            @(negedge d_Clk);
            k++;
        end
        chk($sformatf("rx_done_%02h", d), int'(rx_cnt != c0), 1);
        chk($sformatf("rx_byte_%02h", d), int'(rx_byte), int'(d));
        chk($sformatf("rx_ok_%02h", d), int'(rx_ok), 1);
        wait_idle("rx");
        repeat (3) @(negedge d_Clk);
    endtask

    int first_done;

    initial begin
        repeat (3) @(negedge d_Clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_Busy), 0);
        chk("rst_done", int'(tx_Done), 0);
        reset  = 1'b1;
        chk_en = 1'b1;
        repeat (50) @(negedge d_Clk);
        chk("idle_tx", int'(tx), 1);
        chk("idle_busy", int'(tx_Busy), 0);

`ifdef UART_TX_PARITY_EN
        lit_frame("p55", 8'h55, 11'b10010101010, 176);
        lit_frame("p07", 8'h07, 11'b11000001110, 176);
        lit_frame("pA5", 8'hA5, 11'b10101001010, 176);
`else
        lit_frame("A5", 8'hA5, 11'b11101001010, 160);
        lit_frame("55", 8'h55, 11'b11010101010, 160);
        lit_frame("07", 8'h07, 11'b11000001110, 160);
`endif

        // Held start: frames chain with a single idle cycle between them.
        @(negedge d_Clk);
        tx_Data    = 8'h3C;
        tx_Start   = 1'b1;
        first_done = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge d_Clk);
            if (n == 40 || n == 200) tx_Data = 8'hC3;
            if (n == 120 || n == 280) tx_Data = 8'h3C;
            if (first_done >= 0 && n == first_done + 1)
                chk("b2b_start", int'(tx), 0);
            if (tx_Done && first_done < 0) begin
                first_done = n;
                chk("b2b_gap_tx", int'(tx), 1);
            end
        end
        tx_Start = 1'b0;
        chk("b2b_first_done", first_done, FL);
        wait_idle("b2b");
        repeat (5) @(negedge d_Clk);

        // Abort a frame with an asynchronous reset between clock edges.
        @(negedge d_Clk);
        tx_Data  = 8'hFF;
        tx_Start = 1'b1;
        @(negedge d_Clk);
        tx_Start = 1'b0;
        repeat (70) @(negedge d_Clk);
        chk("abort_pre_busy", int'(tx_Busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx", int'(tx), 1);
        chk("abort_busy", int'(tx_Busy), 0);
        chk("abort_done", int'(tx_Done), 0);
        repeat (3) @(negedge d_Clk);
        reset = 1'b1;
`ifdef UART_TX_PARITY_EN
        lit_frame("post", 8'hA5, 11'b10101001010, 176);
`else
        lit_frame("post", 8'hA5, 11'b11101001010, 160);
`endif

        loopback(8'h00);
        loopback(8'hFF);
        loopback(8'h81);

        repeat (5) @(negedge d_Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
